// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl -- stall/flush sequencing for the 5-stage MIPS pipeline.
// Combines load-use hazard detection, branch/jump flush, and the breakpoint
// halt/continue state machine with a synchronised, debounced continue button.
// Optional feature macro: PIPE_SINGLE_STEP_EN (adds step_mode; RESUME returns
// to HALT so each continue press advances exactly one instruction).
module pipeline_hazard_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             jump_taken,
  input  logic             bkpt_hit,
  input  logic             continue_sig,
`ifdef PIPE_SINGLE_STEP_EN
  input  logic             step_mode,
`endif
  output logic             stall,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             halted,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  // Debounce counter only needs to count up to DEBOUNCE_CYCLES-2: the level
  // is taken on the edge where it would reach DEBOUNCE_CYCLES-1.
  localparam int             DBW     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALT   = 2'd1,
    RESUME = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [1:0]     sync_q;
  logic           sync_lvl;
  logic           deb_lvl;
  logic [DBW-1:0] deb_cnt;
  logic           cont_pulse;
  logic           flush;
  logic           lu;
  logic           lu_count;

  assign sync_lvl = sync_q[1];

  // Two-flop synchroniser for the asynchronous continue button.
  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], continue_sig};
  end

  // Debounce: the level follows the synchronised input only after it has
  // disagreed for DEBOUNCE_CYCLES-1 consecutive cycles; any agreement restarts
  // the count. A rising accepted level produces a one-cycle continue pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_lvl    <= 1'b0;
      deb_cnt    <= '0;
      cont_pulse <= 1'b0;
    end else begin
      cont_pulse <= 1'b0;
      if (sync_lvl == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_LAST) begin
        deb_lvl    <= sync_lvl;
        deb_cnt    <= '0;
        cont_pulse <= sync_lvl;
      end else begin
        deb_cnt <= deb_cnt + DBW'(1);
      end
    end
  end

  // Hazard state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // Hazard detection, stall/flush generation and next-state selection.
  // Flush outranks everything: it drops the stall and discards any pending
  // breakpoint or load-use bubble in the same cycle.
  always_comb begin
    flush     = branch_taken | jump_taken;
    lu        = ex_mem_read & (ex_rd != 5'd0) &
                ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    state_nxt = state;
    stall     = 1'b0;
    halted    = 1'b0;
    lu_count  = 1'b0;
    case (state)
      RUN: begin
        stall    = ~flush & (lu | bkpt_hit);
        lu_count = ~flush & lu;
        if (!flush && bkpt_hit) state_nxt = HALT;
      end
      HALT: begin
        // Front end frozen; EX/MEM/WB keep draining behind the stall.
        halted = 1'b1;
        stall  = ~flush;
        if (flush)           state_nxt = RUN;
        else if (cont_pulse) state_nxt = RESUME;
      end
      RESUME: begin
        // bkpt_hit is masked so the breakpoint instruction leaves IF/ID; a
        // load-use bubble here still counts as having released it.
        stall     = ~flush & lu;
        lu_count  = ~flush & lu;
        state_nxt = RUN;
`ifdef PIPE_SINGLE_STEP_EN
        if (step_mode && !flush) state_nxt = HALT;
`endif
      end
      default: state_nxt = RUN;
    endcase
  end

  assign flush_if = flush;
  assign flush_id = flush;
  assign flush_ex = flush;

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk) begin
    if (!rst_n)                                 lu_stall_cnt <= '0;
    else if (lu_count && (lu_stall_cnt != '1)) lu_stall_cnt <= lu_stall_cnt + CNT_W'(1);
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline.
- Produces the stall and flush controls for IF/ID/EX from load-use hazards, resolved branches and jumps, and breakpoints.
- Runs the breakpoint halt/continue state machine, with a synchronised, debounced continue button.
- Replaces the purely combinational flush logic; sits at the CPU top level beside the stage modules.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before the continue input is accepted (must be >= 2).
- CNT_W, 16: width of the load-use stall counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- id_rs  in  5  rs field of the instruction in IF/ID
- id_rt  in  5  rt field of the instruction in IF/ID
- id_uses_rt  in  1  IF/ID instruction reads rt
- ex_rd  in  5  destination register of the instruction in ID/EX (after reg_dst select)
- ex_mem_read  in  1  ID/EX instruction is a load
- branch_taken  in  1  branch resolved taken in MEM
- jump_taken  in  1  jump resolved in MEM
- bkpt_hit  in  1  IF/ID holds a breakpoint instruction
- continue_sig  in  1  raw asynchronous continue button level
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX
- flush_if  out  1  squash IF/ID
- flush_id  out  1  squash ID/EX
- flush_ex  out  1  squash EX/MEM
- halted  out  1  pipeline held at a breakpoint
- lu_stall_cnt  out  CNT_W  count of load-use stall cycles

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=RUN; stall, flush_*, halted = 0; lu_stall_cnt = 0.
  - Synchroniser flops and debounced level cleared to 0; debounce counter = 0.
- Flush (combinational, same cycle):
  - flush_if = flush_id = flush_ex = branch_taken | jump_taken, in every state.
  - Flush has top priority: when asserted, stall = 0 and any pending load-use or breakpoint is discarded.
- Load-use hazard (combinational):
  - lu = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
  - In RUN with no flush, lu drives stall = 1 for that cycle. The bubble clears the condition, so the stall lasts exactly 1 cycle.
  - lu_stall_cnt increments on each such cycle and saturates at all-ones.
- Continue input conditioning:
  - 2-flop synchroniser feeds a debounce counter.
  - The counter resets whenever the synchronised value equals the debounced level; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronised value.
  - cont_pulse = 1-cycle pulse on a 0->1 transition of the debounced level.
  - cont_pulse is ignored outside HALT.
- State machine: states RUN, HALT, RESUME.
  - RUN: bkpt_hit & no flush -> stall = 1 this cycle; next state HALT. A load-use hazard in the same cycle is also covered by the stall and counted.
  - HALT:
    - stall = 1, halted = 1.
    - EX/MEM/WB continue to drain.
    - Flush -> RUN (breakpoint squashed, halted drops next cycle).
    - cont_pulse -> RESUME.
  - RESUME:
    - Exactly 1 cycle; halted = 0; bkpt_hit is masked so the breakpoint instruction advances.
    - Load-use and flush handling are as in RUN.
    - Next state is RUN unconditionally; if lu stalls that cycle, stall = 1 but the breakpoint is still considered released.
- Simultaneous events:
  - flush + bkpt_hit in RUN -> flush wins; stay RUN.
  - flush + cont_pulse in HALT -> RUN.
- Latency:
  - stall and flush_* are combinational from inputs.
  - halted rises the cycle after bkpt_hit is accepted.
  - Continue reaches the pipeline 2 + DEBOUNCE_CYCLES cycles after a clean button edge.
- Mid-operation reset: any state returns to RUN with all outputs 0 on the first clk edge with rst_n=0.

Optional Feature:
- Macro: PIPE_SINGLE_STEP_EN.
- When defined:
  - Adds input port step_mode (1 bit).
  - In HALT with step_mode=1, cont_pulse -> RESUME -> back to HALT (skipping RUN), advancing exactly one instruction per press.
  - Flush during RESUME still goes to RUN.
- When undefined: no step_mode port; RESUME always goes to RUN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, flushes 0 -> stall=1 for one cycle; lu_stall_cnt 0->1. Same with ex_rd=0 -> stall=0, count unchanged.
- Branch priority: branch_taken=1 together with the lu condition -> flush_if/id/ex=1, stall=0, lu_stall_cnt unchanged.
- Breakpoint: bkpt_hit=1 in RUN -> stall=1 at once, halted=1 next cycle. continue_sig 0->1 held 10 cycles (DEBOUNCE_CYCLES=4) -> RESUME 6 cycles after the edge: stall=0, halted=0, then RUN with bkpt_hit still 1 ignored.
- Bounce: continue_sig toggles every cycle for 20 cycles in HALT -> no cont_pulse; halted stays 1.
- Flush in HALT: jump_taken=1 while halted -> flush_*=1, stall=0 that cycle; halted=0 next cycle; state RUN.
- Reset mid-HALT: rst_n=0 for one edge -> halted=0, stall=0, lu_stall_cnt=0; with PIPE_SINGLE_STEP_EN and step_mode=1, two continue presses -> exactly two RESUME cycles, halted returns to 1 after each.
